line_memory_responder: RTL
==========================

# line_memory_responder

Memory-side responder for the cache line bus. It sits below the direct-mapped cache as the far end of the command/bus handshake. It accepts whole-line store (writeback) and load (refill) commands, holds them for a fixed access latency, commits stores to an internal line array, and returns load lines with a valid/ready handshake. It is the backing memory for cache bring-up and for system-level verification.

## Interface
- ADDR_WIDTH, 64, command address width
- DATA_WIDTH, 64, word width
- OFFSET_LENGTH, 5, log2 words per line; line width LINE_W = DATA_WIDTH*2**OFFSET_LENGTH
- MEM_LINES_LOG2, 8, log2 number of stored lines
- LATENCY, 4, busy cycles per command; legal range 1..255

Ports:
- clk, in, 1, the single clock.
- reset, in, 1, synchronous, active-high.
- command_valid, in, 1, command present.
- command_store, in, 1, 1 = store (writeback), 0 = load (refill).
- command_rready, in, 1, cache can accept the load response.
- command_addr, in, ADDR_WIDTH, line address.
- data_to_bus, in, LINE_W, store line.
- bus_ready, out, 1, the responder accepts a command this cycle.
- bus_valid, out, 1, load response present.
- data_from_bus, out, LINE_W, load response line.

## Operation
- Line index = command_addr[OFFSET_LENGTH+MEM_LINES_LOG2-1 : OFFSET_LENGTH].
  - Offset bits and upper bits are ignored, so addresses alias modulo 2**MEM_LINES_LOG2 lines.
- Per-line written bit vector, cleared by reset.
  - A load of a line whose bit is clear returns all zeros.
  - The line array data itself is not reset.
- FSM states:
  - IDLE: bus_ready=1. Accept = command_valid && bus_ready.
    - Store accept: data_to_bus is written to the array and the line's written bit is set at that edge. Go to BUSY.
    - Load accept: latch the index and the store/load kind. Go to BUSY.
  - BUSY: bus_ready=0. The counter loads LATENCY-1 on accept and decrements each cycle. At count 0:
    - store → IDLE
    - load → RESPOND. The line is read from the array on the BUSY→RESPOND edge.
  - RESPOND: bus_valid=1, data_from_bus=latched line. Stays until command_rready=1, then → IDLE.
- Command inputs are ignored outside IDLE. Holding command_valid high in BUSY or RESPOND has no effect.
- data_from_bus stays stable throughout RESPOND. Outside RESPOND it holds its last value; the bench must not check it there.
- Ordering: a load issued after a store to the same line returns the stored data, because the store commits at its accept edge.
- Reset, including mid-operation, forces IDLE:
  - any pending response is dropped;
  - all written bits are cleared;
  - the counter is cleared.

## Timing
- Reset values: bus_ready=1 (IDLE), bus_valid=0, data_from_bus=0.
- Accept at cycle 0 → BUSY for cycles 1..LATENCY → either:
  - store: bus_ready=1 at cycle LATENCY+1;
  - load: bus_valid=1 from cycle LATENCY+1.
- Load response completes on the first cycle where bus_valid && command_rready. bus_ready=1 on the following cycle.
- Back-to-back throughput:
  - one store per LATENCY+1 cycles;
  - one load per LATENCY+2 cycles when command_rready is held high.
- No combinational path from any input to any output except none. All outputs are registered or decoded from state only.

## Structure
- Shared package (cache_bus_pkg) holds:
  - LINE_W-derived typedef line_t;
  - cmd enum {CMD_LOAD, CMD_STORE};
  - responder state enum {RSP_IDLE, RSP_BUSY, RSP_RESPOND}.
  - The cache side imports the same package.
- One sub-module, line_store: line array plus written-bit vector, with one synchronous write port and one synchronous read port that returns zero for unwritten lines. The FSM and latency counter live in the top module.

## Test plan
- Reset, then load addr 0x40 (LATENCY=4) → bus_valid rises at cycle 5 with data all zeros; bus_ready returns the cycle after command_rready.
- Store line pattern 0xA5..A5 to 0x1000, then load 0x1000 → bus_ready low for cycles 1–4 after the store; the load returns 0xA5..A5.
- Store to index 3, then load from an address whose upper bits differ but whose index is 3 → aliased data is returned.
- Load with command_rready low for 10 cycles → bus_valid and data stay stable; a second command_valid raised meanwhile is not accepted.
- Assert reset during BUSY of a load → next cycle bus_ready=1 and bus_valid=0; a previously stored line now reads zero.
- LATENCY=1: store then load back-to-back → store cycle spacing is 2; load response arrives at cycle 2.

Source files
------------

// File: rtl/cache_bus_pkg.sv
// Shared definitions for the cache line bus, used by both the cache side and
// the memory-side responder.
//   - BUS_* constants: default bus geometry
//   - line_t         : one whole cache line at the default geometry
//   - cmd_t          : command kind carried by command_store
//   - rsp_state_t    : responder FSM states
package cache_bus_pkg;

  localparam int BUS_ADDR_WIDTH    = 64;
  localparam int BUS_DATA_WIDTH    = 64;
  localparam int BUS_OFFSET_LENGTH = 5;
  localparam int BUS_LINE_W        = BUS_DATA_WIDTH * (2 ** BUS_OFFSET_LENGTH);

  typedef logic [BUS_LINE_W-1:0] line_t;

  typedef enum logic {
    CMD_LOAD  = 1'b0,
    CMD_STORE = 1'b1
  } cmd_t;

  typedef enum logic [1:0] {
    RSP_IDLE    = 2'd0,
    RSP_BUSY    = 2'd1,
    RSP_RESPOND = 2'd2
  } rsp_state_t;

endpackage

// File: rtl/line_store.sv
// Line array plus a per-line written bit. One synchronous write port and one
// synchronous read port; reading a line that was never written since reset
// returns all zeros.
//   clk, reset          : clock, synchronous active-high reset
//   wr_en/wr_index/wr_data : line write, committed at the clock edge
//   rd_en/rd_index      : registered read request
//   rd_data             : read result, holds its value when rd_en is low
module line_store #(
  parameter int LINE_W  = 2048,
  parameter int INDEX_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [LINE_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [INDEX_W-1:0] rd_index,
  output logic [LINE_W-1:0] rd_data
);

  localparam int LINES = 1 << INDEX_W;

  logic [LINE_W-1:0] lines [LINES];
  logic [LINES-1:0]  written;

  // NOTE: the array itself is never reset (it maps onto RAM); the written
  // vector is what makes stale contents invisible after reset.
  always_ff @(posedge clk) begin
    if (wr_en) lines[wr_index] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset)      written <= '0;
    else if (wr_en) written[wr_index] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= written[rd_index] ? lines[rd_index] : '0;
  end

endmodule

// File: rtl/line_memory_responder.sv
// Memory-side responder for the cache line bus. Accepts whole-line store and
// load commands, stays busy for LATENCY cycles, commits stores to line_store
// at the accept edge and returns load lines with a valid/ready handshake.
//   clk, reset     : clock, synchronous active-high reset
//   command_valid  : command present (sampled only in IDLE)
//   command_store  : 1 = store (writeback), 0 = load (refill)
//   command_rready : cache accepts the load response
//   command_addr   : line address; only the index bits are used
//   data_to_bus    : store line
//   bus_ready      : responder accepts a command this cycle (IDLE)
//   bus_valid      : load response present (RESPOND)
//   data_from_bus  : load response line, stable while bus_valid is high
module line_memory_responder
  import cache_bus_pkg::*;
#(
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 64,
  parameter int OFFSET_LENGTH  = 5,
  parameter int MEM_LINES_LOG2 = 8,
  parameter int LATENCY        = 4,
  localparam int LINE_W        = DATA_WIDTH * (2 ** OFFSET_LENGTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  command_valid,
  input  logic                  command_store,
  input  logic                  command_rready,
  input  logic [ADDR_WIDTH-1:0] command_addr,
  input  logic [LINE_W-1:0]     data_to_bus,
  output logic                  bus_ready,
  output logic                  bus_valid,
  output logic [LINE_W-1:0]     data_from_bus
);

  rsp_state_t                state;
  cmd_t                      kind;
  logic [7:0]                count;
  logic [MEM_LINES_LOG2-1:0] index;
  logic [MEM_LINES_LOG2-1:0] cmd_index;
  logic                      accept;
  logic                      wr_en;
  logic                      rd_en;
  logic                      unused_addr;

  // Offset and upper address bits are dropped, so addresses alias modulo
  // the number of stored lines.
  assign cmd_index   = command_addr[OFFSET_LENGTH+MEM_LINES_LOG2-1 : OFFSET_LENGTH];
  assign unused_addr = ^{1'b0, command_addr};

  assign accept = (state == RSP_IDLE) && command_valid;
  assign wr_en  = accept && command_store;
  // Load data is fetched on the BUSY->RESPOND edge.
  assign rd_en  = (state == RSP_BUSY) && (count == 8'd0) && (kind == CMD_LOAD);

  // NOTE: all state updates use non-blocking assignments so every register
  // sees the pre-edge values of the others, whatever the statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RSP_IDLE;
      kind  <= CMD_LOAD;
      count <= 8'd0;
      index <= '0;
    end else begin
      case (state)
        RSP_IDLE: begin
          if (command_valid) begin
            kind  <= command_store ? CMD_STORE : CMD_LOAD;
            index <= cmd_index;
            count <= 8'(LATENCY - 1);
            state <= RSP_BUSY;
          end
        end
        RSP_BUSY: begin
          if (count == 8'd0) state <= (kind == CMD_STORE) ? RSP_IDLE : RSP_RESPOND;
          else               count <= count - 8'd1;
        end
        RSP_RESPOND: begin
          if (command_rready) state <= RSP_IDLE;
        end
        default: state <= RSP_IDLE;
      endcase
    end
  end

  assign bus_ready = (state == RSP_IDLE);
  assign bus_valid = (state == RSP_RESPOND);

  line_store #(
    .LINE_W  (LINE_W),
    .INDEX_W (MEM_LINES_LOG2)
  ) u_line_store (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_index (cmd_index),
    .wr_data  (data_to_bus),
    .rd_en    (rd_en),
    .rd_index (index),
    .rd_data  (data_from_bus)
  );

endmodule
